// File: rtl/life_pkg.sv
// Shared types for the Game of Life neighbourhood datapath: the window
// generator's state encoding, the 3x3 window layout and a helper that sizes
// row/column/index counters.
package life_pkg;

   // Frame phases of the window generator.
   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } life_state_e;

   // One 3x3 neighbourhood; c is the centre, the rest are its eight
   // neighbours from top-left to bottom-right.
   typedef struct packed {
      logic tl;
      logic t;
      logic tr;
      logic l;
      logic c;
      logic r;
      logic bl;
      logic b;
      logic br;
   } life_window_t;

   // Bits needed for a counter holding 0 .. n-1 (never less than one bit).
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/life_line_buf.sv
// Raster line buffer for the window generator. It spans 2*WIDTH+3 cells:
// the cell being shifted in plus 2*WIDTH+2 stored cells. The nine taps show
// that span as it stands after the shift, so the parent can register a
// complete window on the same edge that performs the step.
module life_line_buf #(
   parameter int WIDTH = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic din,
   output logic tap_tl,
   output logic tap_t,
   output logic tap_tr,
   output logic tap_l,
   output logic tap_c,
   output logic tap_r,
   output logic tap_bl,
   output logic tap_b,
   output logic tap_br
);

   localparam int LEN = 2 * WIDTH + 3;

   logic [LEN-2:0] hist_q;
   logic [LEN-2:0] hist_d;
   logic [LEN-1:0] span;

   // Position 0 is the newest cell; position p is p cells older in raster order.
   assign span = {hist_q, din};

   // Advance the history by one cell whenever a step fires.
   always_comb begin
      hist_d = hist_q;
      if (en) begin
         hist_d = span[LEN-2:0];
      end
   end

   // History register with synchronous clear.
   always_ff @(posedge clk) begin
      // NOTE: this storage is a handful of flops, so it is cleared on reset;
      // non-blocking assignment keeps every flop sampling pre-edge values.
      if (!rst_n) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   // With the newest cell being index j+WIDTH+1, centre j sits at WIDTH+1.
   assign tap_br = span[0];
   assign tap_b  = span[1];
   assign tap_bl = span[2];
   assign tap_r  = span[WIDTH];
   assign tap_c  = span[WIDTH+1];
   assign tap_l  = span[WIDTH+2];
   assign tap_tr = span[2*WIDTH];
   assign tap_t  = span[2*WIDTH+1];
   assign tap_tl = span[2*WIDTH+2];

endmodule

// File: rtl/life_window_gen.sv
// Streaming 3x3 neighbourhood generator for the Game of Life datapath.
// Takes one generation as a raster-order cell stream and emits, per cell,
// its eight neighbours plus centre, with out-of-grid neighbours forced to 0.
// Optional feature: define LIFE_GEN_CNT_EN to add the gen_count port, which
// counts completed generations (accepted out_last windows), wrapping at 2^16.
module life_window_gen
   import life_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_cell,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        Tl,
   output logic        T,
   output logic        Tr,
   output logic        L,
   output logic        R,
   output logic        Bl,
   output logic        B,
   output logic        Br,
   output logic        C,
   output logic        out_last
`ifdef LIFE_GEN_CNT_EN
   ,
   output logic [15:0] gen_count
`endif
);

   localparam int N  = WIDTH * HEIGHT;
   localparam int IW = idx_w(N);
   localparam int CW = idx_w(WIDTH);
   localparam int RW = idx_w(HEIGHT);

   localparam logic [IW-1:0] FILL_LAST = IW'(WIDTH);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);

   life_state_e   state_q, state_d;
   logic [IW-1:0] in_idx_q, in_idx_d;
   logic [CW-1:0] out_col_q, out_col_d;
   logic [RW-1:0] out_row_q, out_row_d;
   life_window_t  win_q, win_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
`ifdef LIFE_GEN_CNT_EN
   logic [15:0]   gen_count_q, gen_count_d;
`endif

   logic slot_free;
   logic step;
   logic emit;
   logic shift_bit;
   logic first_row, last_row, first_col, last_col;
   logic tap_tl, tap_t, tap_tr, tap_l, tap_c, tap_r, tap_bl, tap_b, tap_br;

   // A step needs a free output slot; outside FLUSH it also needs an input cell.
   assign slot_free = !out_valid_q || out_ready;
   assign step      = slot_free && ((state_q == FLUSH) || in_valid);
   assign emit      = step && (state_q != FILL);
   assign in_ready  = (state_q != FLUSH) && slot_free;
   assign shift_bit = (state_q == FLUSH) ? 1'b0 : in_cell;

   // Border flags for the window being produced by this step.
   assign first_row = (out_row_q == '0);
   assign last_row  = (out_row_q == ROW_LAST);
   assign first_col = (out_col_q == '0);
   assign last_col  = (out_col_q == COL_LAST);

   life_line_buf #(
      .WIDTH (WIDTH)
   ) u_line_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (step),
      .din    (shift_bit),
      .tap_tl (tap_tl),
      .tap_t  (tap_t),
      .tap_tr (tap_tr),
      .tap_l  (tap_l),
      .tap_c  (tap_c),
      .tap_r  (tap_r),
      .tap_bl (tap_bl),
      .tap_b  (tap_b),
      .tap_br (tap_br)
   );

   // Next-state, counters, masked window and output handshake.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would infer a latch.
      state_d     = state_q;
      in_idx_d    = in_idx_q;
      out_col_d   = out_col_q;
      out_row_d   = out_row_q;
      win_d       = win_q;
      out_valid_d = out_valid_q && !out_ready;
      out_last_d  = out_last_q && !out_ready;
`ifdef LIFE_GEN_CNT_EN
      gen_count_d = gen_count_q;
      if (out_valid_q && out_ready && out_last_q) begin
         gen_count_d = gen_count_q + 16'd1;
      end
`endif

      case (state_q)
         FILL: begin
            if (step) begin
               in_idx_d = in_idx_q + 1'b1;
               if (in_idx_q == FILL_LAST) begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (step) begin
               if (in_idx_q == IDX_LAST) begin
                  in_idx_d = '0;
                  state_d  = FLUSH;
               end else begin
                  in_idx_d = in_idx_q + 1'b1;
               end
            end
         end
         FLUSH: begin
            if (step && last_row && last_col) begin
               state_d = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase

      if (emit) begin
         win_d.tl    = tap_tl && !first_row && !first_col;
         win_d.t     = tap_t  && !first_row;
         win_d.tr    = tap_tr && !first_row && !last_col;
         win_d.l     = tap_l  && !first_col;
         win_d.c     = tap_c;
         win_d.r     = tap_r  && !last_col;
         win_d.bl    = tap_bl && !last_row && !first_col;
         win_d.b     = tap_b  && !last_row;
         win_d.br    = tap_br && !last_row && !last_col;
         out_valid_d = 1'b1;
         out_last_d  = last_row && last_col;
         if (last_col) begin
            out_col_d = '0;
            out_row_d = last_row ? '0 : out_row_q + 1'b1;
         end else begin
            out_col_d = out_col_q + 1'b1;
         end
      end
   end

   // State, counters and registered outputs with synchronous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= FILL;
         in_idx_q    <= '0;
         out_col_q   <= '0;
         out_row_q   <= '0;
         win_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef LIFE_GEN_CNT_EN
         gen_count_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         in_idx_q    <= in_idx_d;
         out_col_q   <= out_col_d;
         out_row_q   <= out_row_d;
         win_q       <= win_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
`ifdef LIFE_GEN_CNT_EN
         gen_count_q <= gen_count_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign Tl        = win_q.tl;
   assign T         = win_q.t;
   assign Tr        = win_q.tr;
   assign L         = win_q.l;
   assign C         = win_q.c;
   assign R         = win_q.r;
   assign Bl        = win_q.bl;
   assign B         = win_q.b;
   assign Br        = win_q.br;
`ifdef LIFE_GEN_CNT_EN
   assign gen_count = gen_count_q;
`endif

endmodule
